// File: rtl/amba3_apb_arbiter.sv
// Round-robin arbiter sharing one AMBA 3 APB master among NUM_REQ requesters; optional lock via AMBA3_APB_ARB_LOCK_EN.
// Accept T -> SETUP T+1 -> ACCESS T+2, rsp_valid one cycle after pready; req_ready only at arbitration points, no response backpressure.
module amba3_apb_arbiter #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int NUM_REQ   = 4
) (
    input  logic                           pclk,
    input  logic                           preset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
`ifdef AMBA3_APB_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_lock,
`endif
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_SIZE-1:0]           rsp_rdata,
    output logic                           rsp_slverr,
    output logic [ADDR_SIZE-1:0]           paddr,
    output logic                           pwrite,
    output logic [DATA_SIZE-1:0]           pwdata,
    output logic                           psel,
    output logic                           penable,
    input  logic [DATA_SIZE-1:0]           prdata,
    input  logic                           pready,
    input  logic                           pslverr
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   rr_win;
    logic [PW-1:0]   win;
    logic            rr_found;
    logic            lock_hit;
    logic            done;
    logic            arb_point;
    logic            accept;

    // Search upward from ptr+1 so the last grantee has lowest priority.
    always_comb begin
        logic [PW-1:0] cand;
        rr_found = 1'b0;
        rr_win   = ptr;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % NUM_REQ);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
    end

`ifdef AMBA3_APB_ARB_LOCK_EN
    logic lock_q;
    assign lock_hit = lock_q & req_valid[grant];
`else
    assign lock_hit = 1'b0;
`endif

    assign win       = lock_hit ? grant : rr_win;
    assign done      = (state == ACCESS) && pready;
    // Gated by reset so nothing is handed off in a cycle the reset will discard.
    assign arb_point = preset_n && ((state == IDLE) || done);
    assign accept    = arb_point && (lock_hit || rr_found);
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

    assign psel      = (state != IDLE);
    assign penable   = (state == ACCESS);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready) state_nxt = accept ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state      <= IDLE;
            ptr        <= PW'(NUM_REQ - 1);
            grant      <= '0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
`ifdef AMBA3_APB_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant  <= win;
                paddr  <= req_addr[int'(win)*ADDR_SIZE +: ADDR_SIZE];
                pwrite <= req_write[win];
                pwdata <= req_wdata[int'(win)*DATA_SIZE +: DATA_SIZE];
                if (!lock_hit) begin
                    ptr <= win;
                end
            end
            rsp_valid <= done ? (NUM_REQ'(1) << grant) : '0;
            if (done) begin
                rsp_rdata  <= pwrite ? '0 : prdata;
                rsp_slverr <= pslverr;
            end
`ifdef AMBA3_APB_ARB_LOCK_EN
            // An arbitration point without a grant releases any held lock.
            if (arb_point) begin
                lock_q <= accept & req_lock[win];
            end
`endif
        end
    end

endmodule
